// File: rtl/hazard_pkg.sv
// Shared state encoding and defaults for the 5-stage pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int REG_IDX_W   = 5;

  // Instruction word the fetch side loads into IF/ID when if_id_flush is high.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the load in EX and the sources read in ID.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 lu
);

  logic [REG_IDX_W-1:0] src_idx [2];
  logic [1:0]           src_use;
  logic [1:0]           src_hit;

  assign src_idx[0] = id_rs1;
  assign src_idx[1] = id_rs2;
  assign src_use    = {id_use_rs2, id_use_rs1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_use[gi] && (src_idx[gi] == ex_rd);
  end

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign lu = ex_mem_read && (ex_rd != '0) && (|src_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, EX redirects, data-memory waits
// with timeout, plus saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_hold,
  output logic                 mem_wb_bubble,
  output logic                 mem_fault,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_t             state_reg, state_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic               pending_reg, pending_next;
  logic [CNT_W-1:0]   stall_cnt_reg, flush_cnt_reg;
  logic               lu, mem_stall, run_events, redirect_taken;

  hazard_detect u_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu          (lu)
  );

  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_hold    = 1'b0;
    mem_wb_bubble  = 1'b0;
    mem_fault      = 1'b0;
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    pending_next   = pending_reg;
    run_events     = 1'b0;
    redirect_taken = 1'b0;

    case (state_reg)
      MEM_WAIT: begin
        if (mem_ready) begin
          wait_cnt_next = '0;
          pending_next  = 1'b0;
          state_next    = pending_reg ? FLUSH : RUN;
          run_events    = 1'b1;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // Abandon the access: unfreeze, but keep MEM/WB from committing it.
          mem_fault     = 1'b1;
          mem_wb_bubble = 1'b1;
          wait_cnt_next = '0;
          pending_next  = 1'b0;
          state_next    = RUN;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
          wait_cnt_next = wait_cnt_reg + WAIT_ONE;
        end
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        state_next  = RUN;
        if (mem_stall) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
          pending_next  = 1'b1;
          wait_cnt_next = WAIT_ONE;
          state_next    = MEM_WAIT;
        end
      end
      default: begin
        // The entry cycle is itself the first wait cycle, hence the count starts at one.
        if (mem_stall) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
          wait_cnt_next = WAIT_ONE;
          state_next    = MEM_WAIT;
        end else begin
          run_events = 1'b1;
        end
      end
    endcase

    if (run_events) begin
      if (ex_redirect) begin
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        redirect_taken = 1'b1;
        state_next     = FLUSH;
      end else if (lu) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
      ex_mem_hold   = 1'b0;
      mem_fault     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      pending_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      pending_reg  <= pending_next;
      if (!pc_write && !(&stall_cnt_reg))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (redirect_taken && !(&flush_cnt_reg))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign state        = rst_n ? state_reg : RUN;
  assign stall_cycles = stall_cnt_reg;
  assign flush_count  = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output vectors are queued per cycle and checked mid-cycle.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int TB_CNT_W   = 4;
  localparam int TB_TIMEOUT = 4;

  // Output pattern order: pc_write, if_id_write, if_id_flush, id_ex_flush,
  // ex_mem_hold, mem_wb_bubble, mem_fault.
  localparam logic [6:0] O_RUN    = 7'b1100000;
  localparam logic [6:0] O_LU     = 7'b0001000;
  localparam logic [6:0] O_REDIR  = 7'b1111000;
  localparam logic [6:0] O_FREEZE = 7'b0000110;
  localparam logic [6:0] O_FLUSH  = 7'b1110000;
  localparam logic [6:0] O_FLFRZ  = 7'b0010110;
  localparam logic [6:0] O_FAULT  = 7'b1100011;
  localparam logic [6:0] O_RST    = 7'b0011010;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_FL  = 2'd2;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_hold, mem_wb_bubble, mem_fault;
  logic [1:0] state;
  logic [TB_CNT_W-1:0] stall_cycles, flush_count;
  logic [8:0] obs_vec;
  logic [8:0] sb_q [$];
  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(TB_CNT_W), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_hold(ex_mem_hold), .mem_wb_bubble(mem_wb_bubble),
    .mem_fault(mem_fault), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign obs_vec = {pc_write, if_id_write, if_id_flush, id_ex_flush,
                    ex_mem_hold, mem_wb_bubble, mem_fault, state};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("[TB] ok %s: %h", tag, obs);
    end
  endtask

  // Start a new cycle on the falling edge with all inputs idle.
  task automatic nxt();
    @(negedge clk);
    rst_n = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic [6:0] pat, input logic [1:0] st);
    logic [8:0] e;
    sb_q.push_back({pat, st});
    #1;
    e = sb_q.pop_front();
    chk(tag, 32'(obs_vec), 32'(e));
  endtask

  task automatic cnt_chk(input string tag, input logic [TB_CNT_W-1:0] s, input logic [TB_CNT_W-1:0] f);
    chk({tag, "_stall"}, 32'(stall_cycles), 32'(s));
    chk({tag, "_flush"}, 32'(flush_count), 32'(f));
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 1'b0;
    cyc("reset", O_RST, S_RUN);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    // Reset values, then load-use on rs1, x0 destination, rs2, and unused rs2.
    do_reset();
    do_reset();
    nxt(); cyc("post_reset", O_RUN, S_RUN);
    cnt_chk("reset", 0, 0);
    nxt(); set_lu(); cyc("lu_rs1", O_LU, S_RUN);
    nxt(); cyc("lu_clear", O_RUN, S_RUN);
    cnt_chk("lu", 1, 0);
    nxt(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1; cyc("lu_x0", O_RUN, S_RUN);
    nxt(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; cyc("lu_rs2", O_LU, S_RUN);
    nxt(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; cyc("lu_rs2_unused", O_RUN, S_RUN);
    nxt(); set_lu(); ex_mem_read = 1'b0; cyc("lu_no_load", O_RUN, S_RUN);
    nxt(); set_lu(); mem_req = 1'b1; mem_ready = 1'b1; cyc("lu_mem_ready", O_LU, S_RUN);
    nxt(); cyc("lu_idle", O_RUN, S_RUN);
    cnt_chk("lu2", 3, 0);

    // Redirect: flush both front registers, one FLUSH cycle, back to RUN.
    do_reset();
    nxt(); ex_redirect = 1'b1; cyc("redir", O_REDIR, S_RUN);
    nxt(); cyc("redir_flush", O_FLUSH, S_FL);
    nxt(); cyc("redir_run", O_RUN, S_RUN);
    cnt_chk("redir", 0, 1);

    // Three-cycle memory wait released in the ready cycle.
    do_reset();
    nxt(); mem_req = 1'b1; cyc("mw_enter", O_FREEZE, S_RUN);
    nxt(); mem_req = 1'b1; cyc("mw_wait2", O_FREEZE, S_MW);
    nxt(); mem_req = 1'b1; cyc("mw_wait3", O_FREEZE, S_MW);
    nxt(); mem_req = 1'b1; mem_ready = 1'b1; cyc("mw_ready", O_RUN, S_MW);
    nxt(); cyc("mw_run", O_RUN, S_RUN);
    cnt_chk("mw", 3, 0);

    // Redirect, load-use and memory wait together: memory first, then redirect beats lu.
    do_reset();
    nxt(); set_lu(); ex_redirect = 1'b1; mem_req = 1'b1; cyc("sim_enter", O_FREEZE, S_RUN);
    nxt(); set_lu(); ex_redirect = 1'b1; mem_req = 1'b1; cyc("sim_wait", O_FREEZE, S_MW);
    nxt(); set_lu(); ex_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b1; cyc("sim_ready", O_REDIR, S_MW);
    nxt(); cyc("sim_flush", O_FLUSH, S_FL);
    nxt(); cyc("sim_run", O_RUN, S_RUN);
    cnt_chk("sim", 2, 1);

    // Memory wait starting in FLUSH replays a FLUSH cycle after ready.
    do_reset();
    nxt(); ex_redirect = 1'b1; cyc("pf_redir", O_REDIR, S_RUN);
    nxt(); mem_req = 1'b1; cyc("pf_flush_wait", O_FLFRZ, S_FL);
    nxt(); mem_req = 1'b1; cyc("pf_wait", O_FREEZE, S_MW);
    nxt(); mem_req = 1'b1; mem_ready = 1'b1; cyc("pf_ready", O_RUN, S_MW);
    nxt(); cyc("pf_replay", O_FLUSH, S_FL);
    nxt(); cyc("pf_run", O_RUN, S_RUN);
    cnt_chk("pf", 2, 1);

    // Timeout: fault pulses in the 4th wait cycle and the controller returns to RUN.
    do_reset();
    nxt(); mem_req = 1'b1; cyc("to_w1", O_FREEZE, S_RUN);
    nxt(); mem_req = 1'b1; cyc("to_w2", O_FREEZE, S_MW);
    nxt(); mem_req = 1'b1; cyc("to_w3", O_FREEZE, S_MW);
    nxt(); mem_req = 1'b1; cyc("to_fault", O_FAULT, S_MW);
    nxt(); cyc("to_run", O_RUN, S_RUN);
    cnt_chk("to", 3, 0);

    // Reset in the middle of a memory wait.
    do_reset();
    nxt(); mem_req = 1'b1; cyc("rmw_w1", O_FREEZE, S_RUN);
    nxt(); mem_req = 1'b1; cyc("rmw_w2", O_FREEZE, S_MW);
    nxt(); rst_n = 1'b0; mem_req = 1'b1; cyc("rmw_reset", O_RST, S_RUN);
    nxt(); cyc("rmw_run", O_RUN, S_RUN);
    cnt_chk("rmw", 0, 0);

    // Both counters saturate at all-ones.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      nxt(); set_lu(); cyc("sat_lu", O_LU, S_RUN);
    end
    nxt(); cyc("sat_lu_end", O_RUN, S_RUN);
    cnt_chk("sat_stall", 15, 0);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      nxt(); ex_redirect = 1'b1; cyc("sat_redir", O_REDIR, S_RUN);
      nxt(); cyc("sat_flush", O_FLUSH, S_FL);
    end
    nxt(); cyc("sat_redir_end", O_RUN, S_RUN);
    cnt_chk("sat_flush", 0, 15);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
